// File: rtl/ext_mem_xfer_ctrl.sv
// External-memory <-> on-chip buffer transfer controller.
// Runs one load (ext -> buffer, pipelined reads) or one save (buffer -> ext, one word at a
// time) per start pulse and reports sticky done flags plus a status code.
module ext_mem_xfer_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned EXT_AW    = 32,
  parameter int unsigned BUF_AW    = 16,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [EXT_AW-1:0] i_load_start,
  input  logic [31:0]       i_load_words,
  input  logic [BUF_AW-1:0] i_load_buf_addr,
  input  logic [EXT_AW-1:0] i_save_start,
  input  logic [31:0]       i_save_words,
  input  logic [BUF_AW-1:0] i_save_buf_addr,
  input  logic              i_start_load,
  input  logic              i_start_save,
  input  logic              i_abort,
  output logic              o_mem_rd_req,
  output logic [EXT_AW-1:0] o_mem_rd_addr,
  input  logic              i_mem_rd_gnt,
  input  logic              i_mem_rd_vld,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_mem_wr_req,
  output logic [EXT_AW-1:0] o_mem_wr_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic              i_mem_wr_gnt,
  output logic              o_buf_wr_en,
  output logic [BUF_AW-1:0] o_buf_wr_addr,
  output logic [DATA_W-1:0] o_buf_wr_data,
  output logic              o_buf_rd_en,
  output logic [BUF_AW-1:0] o_buf_rd_addr,
  input  logic [DATA_W-1:0] i_buf_rd_data,
  output logic              o_buffer_loaded,
  output logic              o_buffer_saved,
  output logic              o_busy,
  output logic [3:0]        o_status
);

  // Outstanding counter must hold the value MAX_OUTST itself.
  localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
  localparam logic [OW-1:0] MaxOutst = OW'(MAX_OUTST);

  localparam logic [3:0] StatOk      = 4'd0;
  localparam logic [3:0] StatBusy    = 4'd1;
  localparam logic [3:0] StatAbort   = 4'd2;
  localparam logic [3:0] StatCollide = 4'd3;

  typedef enum logic [2:0] {
    StIdle, StLdRun, StSvRd, StSvWait, StSvWr, StDrain, StDone
  } state_e;

  state_e              r_state,    w_state_nxt;
  logic                r_dir_load, w_dir_load_nxt;
  logic [EXT_AW-1:0]   r_ext_addr, w_ext_addr_nxt;
  logic [BUF_AW-1:0]   r_buf_addr, w_buf_addr_nxt;
  logic [31:0]         r_words,    w_words_nxt;
  logic [31:0]         r_issued,   w_issued_nxt;
  logic [31:0]         r_count,    w_count_nxt;
  logic [OW-1:0]       r_outst,    w_outst_nxt;
  logic [DATA_W-1:0]   r_data,     w_data_nxt;
  logic                r_loaded,   w_loaded_nxt;
  logic                r_saved,    w_saved_nxt;
  logic [3:0]          r_status,   w_status_nxt;

  logic w_rd_req;
  logic w_rd_fire;
  logic w_vld_in;
  logic w_buf_wr;

  assign w_rd_req  = (r_state == StLdRun) && (r_issued < r_words) && (r_outst < MaxOutst);
  assign w_rd_fire = w_rd_req && i_mem_rd_gnt;
  // Read data only counts against a request we actually have in flight; stale data after
  // a reset (or with nothing outstanding) is dropped.
  assign w_vld_in  = i_mem_rd_vld && (r_outst != '0) &&
                     ((r_state == StLdRun) || (r_state == StDrain));
  assign w_buf_wr  = w_vld_in && (r_state == StLdRun);
  assign w_outst_nxt = r_outst + OW'(w_rd_fire) - OW'(w_vld_in);

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_dir_load <= 1'b0;
      r_ext_addr <= '0;
      r_buf_addr <= '0;
      r_words    <= '0;
      r_issued   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_data     <= '0;
      r_loaded   <= 1'b0;
      r_saved    <= 1'b0;
      r_status   <= StatOk;
    end else begin
      r_state    <= w_state_nxt;
      r_dir_load <= w_dir_load_nxt;
      r_ext_addr <= w_ext_addr_nxt;
      r_buf_addr <= w_buf_addr_nxt;
      r_words    <= w_words_nxt;
      r_issued   <= w_issued_nxt;
      r_count    <= w_count_nxt;
      r_outst    <= w_outst_nxt;
      r_data     <= w_data_nxt;
      r_loaded   <= w_loaded_nxt;
      r_saved    <= w_saved_nxt;
      r_status   <= w_status_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_dir_load_nxt = r_dir_load;
    w_ext_addr_nxt = r_ext_addr;
    w_buf_addr_nxt = r_buf_addr;
    w_words_nxt    = r_words;
    w_issued_nxt   = r_issued;
    w_count_nxt    = r_count;
    w_data_nxt     = r_data;
    w_loaded_nxt   = r_loaded;
    w_saved_nxt    = r_saved;
    w_status_nxt   = r_status;

    case (r_state)
      StIdle: begin
        // A simultaneous save request loses to the load.
        if (i_start_load) begin
          w_dir_load_nxt = 1'b1;
          w_ext_addr_nxt = i_load_start;
          w_buf_addr_nxt = i_load_buf_addr;
          w_words_nxt    = i_load_words;
          w_issued_nxt   = '0;
          w_count_nxt    = '0;
          w_loaded_nxt   = 1'b0;
          w_status_nxt   = i_start_save ? StatCollide : StatOk;
          w_state_nxt    = (i_load_words == '0) ? StDone : StLdRun;
        end else if (i_start_save) begin
          w_dir_load_nxt = 1'b0;
          w_ext_addr_nxt = i_save_start;
          w_buf_addr_nxt = i_save_buf_addr;
          w_words_nxt    = i_save_words;
          w_issued_nxt   = '0;
          w_count_nxt    = '0;
          w_saved_nxt    = 1'b0;
          w_status_nxt   = StatOk;
          w_state_nxt    = (i_save_words == '0) ? StDone : StSvRd;
        end
      end
      StLdRun: begin
        // Issue side advances on grant, buffer side on returned data.
        if (w_rd_fire) begin
          w_ext_addr_nxt = r_ext_addr + EXT_AW'(1);
          w_issued_nxt   = r_issued + 32'd1;
        end
        if (w_buf_wr) begin
          w_buf_addr_nxt = r_buf_addr + BUF_AW'(1);
          w_count_nxt    = r_count + 32'd1;
          if (r_count + 32'd1 == r_words) w_state_nxt = StDone;
        end
      end
      StSvRd: w_state_nxt = StSvWait;
      StSvWait: begin
        w_data_nxt  = i_buf_rd_data;
        w_state_nxt = StSvWr;
      end
      StSvWr: begin
        if (i_mem_wr_gnt) begin
          w_ext_addr_nxt = r_ext_addr + EXT_AW'(1);
          w_buf_addr_nxt = r_buf_addr + BUF_AW'(1);
          w_count_nxt    = r_count + 32'd1;
          w_state_nxt    = (r_count + 32'd1 == r_words) ? StDone : StSvRd;
        end
      end
      StDrain: begin
        if (w_outst_nxt == '0) w_state_nxt = StIdle;
      end
      StDone: begin
        if (r_dir_load) w_loaded_nxt = 1'b1;
        else            w_saved_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    // Starts while busy are rejected; abort overrides everything, including a done flag.
    if (r_state != StIdle) begin
      if (i_start_load || i_start_save) w_status_nxt = StatBusy;
      if (i_abort && (r_state != StDrain)) begin
        w_status_nxt = StatAbort;
        w_loaded_nxt = r_loaded;
        w_saved_nxt  = r_saved;
        w_state_nxt  = (w_outst_nxt != '0) ? StDrain : StIdle;
      end
    end
  end

  // Output decode
  always_comb begin
    o_mem_rd_req    = w_rd_req;
    o_mem_rd_addr   = r_ext_addr;
    o_mem_wr_req    = (r_state == StSvWr);
    o_mem_wr_addr   = r_ext_addr;
    o_mem_wr_data   = r_data;
    o_buf_wr_en     = w_buf_wr;
    o_buf_wr_addr   = r_buf_addr;
    o_buf_wr_data   = w_buf_wr ? i_mem_rd_data : '0;
    o_buf_rd_en     = (r_state == StSvRd);
    o_buf_rd_addr   = r_buf_addr;
    o_buffer_loaded = r_loaded;
    o_buffer_saved  = r_saved;
    o_busy          = (r_state != StIdle);
    o_status        = r_status;
  end

endmodule

// File: tb/tb_ext_mem_xfer_ctrl.sv
// Bench for ext_mem_xfer_ctrl: behavioural external memory and buffer SRAM, with expected
// transfers computed as plain address/data lists from the start fields.
module tb_ext_mem_xfer_ctrl;

  localparam int unsigned MO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_load_start = '0, i_save_start = '0, i_load_words = '0, i_save_words = '0;
  logic [15:0] i_load_buf_addr = '0, i_save_buf_addr = '0;
  logic        i_start_load = 1'b0, i_start_save = 1'b0, i_abort = 1'b0;
  logic        o_mem_rd_req, i_mem_rd_gnt = 1'b0, i_mem_rd_vld = 1'b0;
  logic [31:0] o_mem_rd_addr, o_mem_wr_addr;
  logic [15:0] i_mem_rd_data = '0, o_mem_wr_data;
  logic        o_mem_wr_req, i_mem_wr_gnt = 1'b0;
  logic        o_buf_wr_en, o_buf_rd_en;
  logic [15:0] o_buf_wr_addr, o_buf_wr_data, o_buf_rd_addr, i_buf_rd_data = '0;
  logic        o_buffer_loaded, o_buffer_saved, o_busy;
  logic [3:0]  o_status;

  always #5 clk = ~clk;

  ext_mem_xfer_ctrl #(.DATA_W(16), .EXT_AW(32), .BUF_AW(16), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_load_start(i_load_start), .i_load_words(i_load_words), .i_load_buf_addr(i_load_buf_addr),
    .i_save_start(i_save_start), .i_save_words(i_save_words), .i_save_buf_addr(i_save_buf_addr),
    .i_start_load(i_start_load), .i_start_save(i_start_save), .i_abort(i_abort),
    .o_mem_rd_req(o_mem_rd_req), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_gnt(i_mem_rd_gnt),
    .i_mem_rd_vld(i_mem_rd_vld), .i_mem_rd_data(i_mem_rd_data),
    .o_mem_wr_req(o_mem_wr_req), .o_mem_wr_addr(o_mem_wr_addr), .o_mem_wr_data(o_mem_wr_data),
    .i_mem_wr_gnt(i_mem_wr_gnt),
    .o_buf_wr_en(o_buf_wr_en), .o_buf_wr_addr(o_buf_wr_addr), .o_buf_wr_data(o_buf_wr_data),
    .o_buf_rd_en(o_buf_rd_en), .o_buf_rd_addr(o_buf_rd_addr), .i_buf_rd_data(i_buf_rd_data),
    .o_buffer_loaded(o_buffer_loaded), .o_buffer_saved(o_buffer_saved), .o_busy(o_busy),
    .o_status(o_status)
  );

  int checks = 0;
  int failures = 0;

  // Responder knobs
  int unsigned rd_lat = 2, rd_prob = 100, wr_delay = 0;
  int          rd_budget = -1;

  // Memory models and observation state
  logic [15:0] ext_mem [logic [31:0]];
  logic [15:0] sram [0:65535];
  logic [31:0] rq_addr [$];
  int unsigned rq_due [$];
  logic [15:0] blog_a [$], blog_d [$], exp_ba [$], exp_bd [$], exp_ed [$], elog_d [$];
  logic [31:0] elog_a [$], exp_ea [$];
  int unsigned cyc = 0, fires = 0, max_outst = 0, rd_req_cycles = 0, wr_wait = 0;
  logic        rd_pend = 1'b0, wr_hold = 1'b0;
  logic [15:0] rd_pend_addr = '0, wr_prev_d = '0;
  logic [31:0] wr_prev_a = '0;

  function automatic logic [15:0] ext_rd(input logic [31:0] a);
    if (ext_mem.exists(a)) return ext_mem[a];
    return a[15:0] ^ {a[7:0], a[31:24]} ^ 16'h5A3C;
  endfunction

  // Monitor: bookkeeping of every transaction, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (o_mem_rd_req && i_mem_rd_gnt) begin
      rq_addr.push_back(o_mem_rd_addr);
      rq_due.push_back(cyc + rd_lat);
      fires++;
      if (rd_budget > 0) rd_budget--;
    end
    if (i_mem_rd_vld) begin
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end
    if (rq_addr.size() > max_outst) max_outst = rq_addr.size();
    if (o_mem_rd_req) rd_req_cycles++;
    if (o_buf_wr_en) begin
      sram[o_buf_wr_addr] = o_buf_wr_data;
      blog_a.push_back(o_buf_wr_addr);
      blog_d.push_back(o_buf_wr_data);
    end
    if (o_mem_wr_req) begin
      if (wr_hold) begin
        checks++;
        if (o_mem_wr_addr !== wr_prev_a || o_mem_wr_data !== wr_prev_d) begin
          failures++;
          $display("FAIL wr_req_stable: got %h/%h want %h/%h", o_mem_wr_addr, o_mem_wr_data,
                   wr_prev_a, wr_prev_d);
        end
      end
      if (i_mem_wr_gnt) begin
        ext_mem[o_mem_wr_addr] = o_mem_wr_data;
        elog_a.push_back(o_mem_wr_addr);
        elog_d.push_back(o_mem_wr_data);
        wr_wait = 0;
        wr_hold = 1'b0;
      end else begin
        wr_wait++;
        wr_hold = 1'b1;
        wr_prev_a = o_mem_wr_addr;
        wr_prev_d = o_mem_wr_data;
      end
    end else begin
      wr_wait = 0;
      wr_hold = 1'b0;
    end
    rd_pend = o_buf_rd_en;
    rd_pend_addr = o_buf_rd_addr;
  end

  // Responder: drives memory-side inputs just after each rising edge
  always begin
    @(posedge clk);
    #1;
    i_mem_rd_gnt = o_mem_rd_req && (rd_budget != 0) && ($urandom_range(99) < rd_prob);
    if (rq_addr.size() != 0 && rq_due[0] <= cyc + 1) begin
      i_mem_rd_vld  = 1'b1;
      i_mem_rd_data = ext_rd(rq_addr[0]);
    end else begin
      i_mem_rd_vld  = 1'b0;
      i_mem_rd_data = 16'($urandom);
    end
    i_mem_wr_gnt  = o_mem_wr_req && (wr_wait >= wr_delay);
    i_buf_rd_data = rd_pend ? sram[rd_pend_addr] : 16'($urandom);
  end

  task automatic model_load(input logic [31:0] s, input int n, input logic [15:0] b);
    exp_ba.delete(); exp_bd.delete();
    for (int i = 0; i < n; i++) begin
      exp_ba.push_back(b + 16'(i));
      exp_bd.push_back(ext_rd(s + 32'(i)));
    end
  endtask

  task automatic model_save(input logic [31:0] s, input int n, input logic [15:0] b);
    exp_ea.delete(); exp_ed.delete();
    for (int i = 0; i < n; i++) begin
      exp_ea.push_back(s + 32'(i));
      exp_ed.push_back(sram[b + 16'(i)]);
    end
  endtask

  task automatic clear_logs();
    blog_a.delete(); blog_d.delete(); elog_a.delete(); elog_d.delete();
  endtask

  task automatic pulse_start(input logic ld, input logic sv);
    @(negedge clk); i_start_load = ld; i_start_save = sv;
    @(negedge clk); i_start_load = 1'b0; i_start_save = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] s, input logic [31:0] n, input logic [15:0] b);
    i_load_start = s; i_load_words = n; i_load_buf_addr = b;
  endtask

  task automatic set_save(input logic [31:0] s, input logic [31:0] n, input logic [15:0] b);
    i_save_start = s; i_save_words = n; i_save_buf_addr = b;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (o_busy && n < max) begin @(negedge clk); n++; end
    checks++;
    if (o_busy) begin failures++; $display("FAIL %s_timeout: busy=%b want 0", name, o_busy); end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rq_addr.size() != 0 && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_status, o_buffer_loaded, o_buffer_saved} !== 7'd0) begin
      failures++;
      $display("FAIL reset_status: got %b%h%b%b want 0", o_busy, o_status, o_buffer_loaded,
               o_buffer_saved);
    end
    checks++;
    if ({o_mem_rd_req, o_mem_wr_req, o_buf_wr_en, o_buf_rd_en} !== 4'd0) begin
      failures++;
      $display("FAIL reset_strobes: got %b%b%b%b want 0000", o_mem_rd_req, o_mem_wr_req,
               o_buf_wr_en, o_buf_rd_en);
    end
    checks++;
    if ({o_mem_rd_addr, o_mem_wr_addr, o_mem_wr_data} !== 80'd0) begin
      failures++;
      $display("FAIL reset_addr: got %h %h %h want 0", o_mem_rd_addr, o_mem_wr_addr, o_mem_wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    rd_lat = 2; rd_prob = 100; rd_budget = -1;
    clear_logs();
    set_load(32'h0000_1000, 32'd3, 16'h0010);
    model_load(32'h0000_1000, 3, 16'h0010);
    pulse_start(1'b1, 1'b0);
    wait_idle("load_basic", 100);
    checks++;
    if (blog_a.size() != exp_ba.size()) begin
      failures++;
      $display("FAIL load_basic_count: got %0d want %0d", blog_a.size(), exp_ba.size());
    end else
      for (int i = 0; i < exp_ba.size(); i++) begin
        checks++;
        if (blog_a[i] !== exp_ba[i] || blog_d[i] !== exp_bd[i]) begin
          failures++;
          $display("FAIL load_basic_w%0d: got %h=%h want %h=%h", i, blog_a[i], blog_d[i],
                   exp_ba[i], exp_bd[i]);
        end
      end
    checks++;
    if (o_buffer_loaded !== 1'b1 || o_status !== 4'd0) begin
      failures++;
      $display("FAIL load_basic_flag: got loaded=%b status=%0d want 1/0", o_buffer_loaded,
               o_status);
    end
  endtask

  task automatic test_save_delayed();
    wr_delay = 3;
    clear_logs();
    sram[5] = 16'($urandom); sram[6] = 16'($urandom);
    set_save(32'h0000_2000, 32'd2, 16'h0005);
    model_save(32'h0000_2000, 2, 16'h0005);
    pulse_start(1'b0, 1'b1);
    wait_idle("save_delayed", 100);
    checks++;
    if (elog_a.size() != exp_ea.size()) begin
      failures++;
      $display("FAIL save_delayed_count: got %0d want %0d", elog_a.size(), exp_ea.size());
    end else
      for (int i = 0; i < exp_ea.size(); i++) begin
        checks++;
        if (elog_a[i] !== exp_ea[i] || elog_d[i] !== exp_ed[i]) begin
          failures++;
          $display("FAIL save_delayed_w%0d: got %h=%h want %h=%h", i, elog_a[i], elog_d[i],
                   exp_ea[i], exp_ed[i]);
        end
      end
    checks++;
    if (o_buffer_saved !== 1'b1 || o_status !== 4'd0) begin
      failures++;
      $display("FAIL save_delayed_flag: got saved=%b status=%0d want 1/0", o_buffer_saved,
               o_status);
    end
    wr_delay = 0;
  endtask

  task automatic test_outstanding();
    rd_lat = 10; max_outst = 0;
    clear_logs();
    set_load(32'h0000_3000, 32'd8, 16'h0100);
    model_load(32'h0000_3000, 8, 16'h0100);
    pulse_start(1'b1, 1'b0);
    wait_idle("outstanding", 300);
    checks++;
    if (blog_a.size() != exp_ba.size()) begin
      failures++;
      $display("FAIL outst_count: got %0d want %0d", blog_a.size(), exp_ba.size());
    end else
      for (int i = 0; i < exp_ba.size(); i++) begin
        checks++;
        if (blog_a[i] !== exp_ba[i] || blog_d[i] !== exp_bd[i]) begin
          failures++;
          $display("FAIL outst_w%0d: got %h=%h want %h=%h", i, blog_a[i], blog_d[i],
                   exp_ba[i], exp_bd[i]);
        end
      end
    checks++;
    if (max_outst != MO) begin
      failures++;
      $display("FAIL outst_max: got %0d want %0d", max_outst, MO);
    end
  endtask

  task automatic test_abort();
    int unsigned f0;
    int n = 0;
    rd_lat = 10; rd_budget = 2;
    clear_logs();
    f0 = fires;
    set_load(32'h0000_4000, 32'd6, 16'h0200);
    pulse_start(1'b1, 1'b0);
    while (fires < f0 + 2 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0;
    checks++;
    if (o_mem_rd_req !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_drop: got req=%b busy=%b want 0/1", o_mem_rd_req, o_busy);
    end
    wait_idle("abort", 100);
    checks++;
    if (blog_a.size() != 0 || o_status !== 4'd2 || o_buffer_loaded !== 1'b0) begin
      failures++;
      $display("FAIL abort_result: got writes=%0d status=%0d loaded=%b want 0/2/0",
               blog_a.size(), o_status, o_buffer_loaded);
    end
    rd_budget = -1;
    wait_drain();
  endtask

  task automatic test_busy_start();
    wr_delay = 2;
    clear_logs();
    for (int i = 0; i < 3; i++) sram[16'h0300 + 16'(i)] = 16'($urandom);
    set_save(32'h0000_5000, 32'd3, 16'h0300);
    model_save(32'h0000_5000, 3, 16'h0300);
    pulse_start(1'b0, 1'b1);
    @(negedge clk);
    set_load(32'h0000_6000, 32'd2, 16'h0040);
    pulse_start(1'b1, 1'b0);
    checks++;
    if (o_status !== 4'd1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_status: got status=%0d busy=%b want 1/1", o_status, o_busy);
    end
    wait_idle("busy_start", 200);
    checks++;
    if (elog_a.size() != exp_ea.size() || blog_a.size() != 0) begin
      failures++;
      $display("FAIL busy_start_count: got %0d/%0d want %0d/0", elog_a.size(), blog_a.size(),
               exp_ea.size());
    end else
      for (int i = 0; i < exp_ea.size(); i++) begin
        checks++;
        if (elog_a[i] !== exp_ea[i] || elog_d[i] !== exp_ed[i]) begin
          failures++;
          $display("FAIL busy_start_w%0d: got %h=%h want %h=%h", i, elog_a[i], elog_d[i],
                   exp_ea[i], exp_ed[i]);
        end
      end
    checks++;
    if (o_buffer_saved !== 1'b1 || o_status !== 4'd1) begin
      failures++;
      $display("FAIL busy_start_flag: got saved=%b status=%0d want 1/1", o_buffer_saved,
               o_status);
    end
    // Both starts from idle: load proceeds, save is dropped.
    rd_lat = 1; wr_delay = 0;
    clear_logs();
    model_load(32'h0000_6000, 2, 16'h0040);
    pulse_start(1'b1, 1'b1);
    wait_idle("collision", 100);
    checks++;
    if (blog_a.size() != exp_ba.size() || elog_a.size() != 0) begin
      failures++;
      $display("FAIL collision_count: got %0d/%0d want %0d/0", blog_a.size(), elog_a.size(),
               exp_ba.size());
    end else
      for (int i = 0; i < exp_ba.size(); i++) begin
        checks++;
        if (blog_a[i] !== exp_ba[i] || blog_d[i] !== exp_bd[i]) begin
          failures++;
          $display("FAIL collision_w%0d: got %h=%h want %h=%h", i, blog_a[i], blog_d[i],
                   exp_ba[i], exp_bd[i]);
        end
      end
    checks++;
    if (o_status !== 4'd3 || o_buffer_loaded !== 1'b1 || o_buffer_saved !== 1'b1) begin
      failures++;
      $display("FAIL collision_flag: got status=%0d loaded=%b saved=%b want 3/1/1", o_status,
               o_buffer_loaded, o_buffer_saved);
    end
  endtask

  task automatic test_wrap_and_zero();
    rd_lat = 3;
    clear_logs();
    set_load(32'hFFFF_FFFF, 32'd2, 16'hFFFF);
    model_load(32'hFFFF_FFFF, 2, 16'hFFFF);
    pulse_start(1'b1, 1'b0);
    wait_idle("wrap", 100);
    checks++;
    if (blog_a.size() != 2) begin
      failures++;
      $display("FAIL wrap_count: got %0d want 2", blog_a.size());
    end else
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (blog_a[i] !== exp_ba[i] || blog_d[i] !== exp_bd[i]) begin
          failures++;
          $display("FAIL wrap_w%0d: got %h=%h want %h=%h", i, blog_a[i], blog_d[i],
                   exp_ba[i], exp_bd[i]);
        end
      end
    // Zero-length load: done one cycle after the start edge, with no traffic.
    clear_logs();
    rd_req_cycles = 0;
    set_load(32'h0000_8000, 32'd0, 16'h0000);
    pulse_start(1'b1, 1'b0);
    checks++;
    if (o_buffer_loaded !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_mid: got loaded=%b busy=%b want 0/1", o_buffer_loaded, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_buffer_loaded !== 1'b1 || o_busy !== 1'b0 || rd_req_cycles != 0 ||
        blog_a.size() != 0) begin
      failures++;
      $display("FAIL zero_done: got loaded=%b busy=%b req=%0d wr=%0d want 1/0/0/0",
               o_buffer_loaded, o_busy, rd_req_cycles, blog_a.size());
    end
  endtask

  task automatic test_reset_mid();
    int unsigned f0;
    int n = 0;
    rd_lat = 6;
    f0 = fires;
    set_load(32'h0000_7000, 32'd5, 16'h0500);
    pulse_start(1'b1, 1'b0);
    while (fires < f0 + 2 && n < 50) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_mem_rd_req !== 1'b0 || o_status !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b req=%b status=%0d want 0/0/0", o_busy, o_mem_rd_req,
               o_status);
    end
    rst_n = 1'b1;
    clear_logs();
    wait_drain();
    checks++;
    if (blog_a.size() != 0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_stale: got writes=%0d busy=%b want 0/0", blog_a.size(), o_busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic        ld;
      logic [31:0] s;
      logic [15:0] b;
      int          n;
      ld = 1'($urandom);
      s = $urandom;
      b = 16'($urandom);
      n = int'($urandom_range(6, 1));
      rd_lat = $urandom_range(5, 1);
      rd_prob = $urandom_range(100, 30);
      wr_delay = $urandom_range(3, 0);
      clear_logs();
      if (ld) begin
        set_load(s, 32'(n), b);
        model_load(s, n, b);
        pulse_start(1'b1, 1'b0);
      end else begin
        for (int i = 0; i < n; i++) sram[b + 16'(i)] = 16'($urandom);
        set_save(s, 32'(n), b);
        model_save(s, n, b);
        pulse_start(1'b0, 1'b1);
      end
      wait_idle("random", 400);
      if (ld) begin
        checks++;
        if (blog_a.size() != n || o_buffer_loaded !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d_load: got n=%0d loaded=%b want %0d/1", it, blog_a.size(),
                   o_buffer_loaded, n);
        end else
          for (int i = 0; i < n; i++) begin
            checks++;
            if (blog_a[i] !== exp_ba[i] || blog_d[i] !== exp_bd[i]) begin
              failures++;
              $display("FAIL rand%0d_w%0d: got %h=%h want %h=%h", it, i, blog_a[i], blog_d[i],
                       exp_ba[i], exp_bd[i]);
            end
          end
      end else begin
        checks++;
        if (elog_a.size() != n || o_buffer_saved !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d_save: got n=%0d saved=%b want %0d/1", it, elog_a.size(),
                   o_buffer_saved, n);
        end else
          for (int i = 0; i < n; i++) begin
            checks++;
            if (elog_a[i] !== exp_ea[i] || elog_d[i] !== exp_ed[i]) begin
              failures++;
              $display("FAIL rand%0d_w%0d: got %h=%h want %h=%h", it, i, elog_a[i], elog_d[i],
                       exp_ea[i], exp_ed[i]);
            end
          end
      end
      checks++;
      if (o_status !== 4'd0) begin
        failures++;
        $display("FAIL rand%0d_status: got %0d want 0", it, o_status);
      end
    end
    rd_prob = 100; wr_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
    test_reset();
    test_load_basic();
    test_save_delayed();
    test_outstanding();
    test_abort();
    test_busy_start();
    test_wrap_and_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
